// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the multi-read-port register file:
//   - FSM state type and encodings (IDLE, CLEAR)
//   - default data width and depth
//   - slice_lsb(): LSB position of port i inside a packed multi-port bus
package reg_file_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 32;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  // Port i of a packed bus whose fields are 'width' bits wide starts at i*width.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port
//   One combinational read port of reg_file_mp. It applies, in priority order,
//   busy gating, the hardwired-zero entry, write-to-read bypass, and finally
//   the stored entry. It also masks the pending flag when the bypass supplies
//   the value in this cycle.
// Ports:
//   busy          in   clear engine active (forces data to zero)
//   addr          in   read index for this port
//   wr_ok         in   a write is being committed this cycle (not discarded)
//   write_addr    in   index of that write
//   write_value   in   data of that write
//   entry         in   stored value at addr
//   entry_pending in   scoreboard bit at addr (0 when the scoreboard is absent)
//   data          out  read data
//   pending       out  source still awaiting its producer
module reg_file_read_port #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            busy,
  input  logic [AW-1:0]   addr,
  input  logic            wr_ok,
  input  logic [AW-1:0]   write_addr,
  input  logic [XLEN-1:0] write_value,
  input  logic [XLEN-1:0] entry,
  input  logic            entry_pending,
  output logic [XLEN-1:0] data,
  output logic            pending
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic bypass_hit_s;

  // A committed write to the same index is forwarded in the same cycle.
  always_comb begin
    bypass_hit_s = wr_ok && (write_addr == addr);
  end

  // Read data priority: busy, hardwired zero, bypass, storage.
  always_comb begin
    data = {XLEN{1'b0}};
    if (busy) begin
      data = {XLEN{1'b0}};
    end else if (HAS_ZERO && (addr == {AW{1'b0}})) begin
      data = {XLEN{1'b0}};
    end else if (bypass_hit_s) begin
      data = write_value;
    end else begin
      data = entry;
    end
  end

  // The value being forwarded satisfies the dependency, so it is not pending.
  always_comb begin
    pending = 1'b0;
    if (bypass_hit_s) begin
      pending = 1'b0;
    end else begin
      pending = entry_pending;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Parametrised register file with NUM_RD combinational read ports, one write
//   port, write-to-read bypass, optional hardwired-zero entry 0 and a
//   sequential clear engine that zeroes one entry per clock after reset or on
//   clear_req.
//   Optional feature macro: REG_FILE_SCOREBOARD_EN adds a per-entry pending
//   scoreboard (issue sets, committed write clears, clear engine wipes).
//   Without it, rd_pending is tied to 0 and issue_en/issue_addr are ignored.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   clear_req    in   start a full clear when idle
//   write_en     in   write strobe
//   write_addr   in   write index
//   write_value  in   write data
//   rd_addr      in   packed read indices, port i at [i*AW +: AW]
//   rd_data      out  packed read data, port i at [i*XLEN +: XLEN]
//   busy         out  clear engine active
//   issue_en     in   mark issue_addr pending (scoreboard build only)
//   issue_addr   in   scoreboard destination index
//   rd_pending   out  per-port pending flag
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  input  logic                   write_en,
  input  logic [AW-1:0]          write_addr,
  input  logic [XLEN-1:0]        write_value,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic                   busy,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic [NUM_RD-1:0]      rd_pending
);

  localparam bit      HAS_ZERO = (ZERO_REG != 0);
  localparam [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_r;
  logic [AW-1:0]   clr_idx_r;
  logic [XLEN-1:0] mem_r [DEPTH];
  logic            wr_ok_s;
  logic            clear_start_s;

  assign busy = (state_r == ST_CLEAR);

  // Writes are dropped while clearing and, with the zero entry, at index 0.
  always_comb begin
    wr_ok_s       = write_en && !busy && !(HAS_ZERO && (write_addr == {AW{1'b0}}));
    clear_start_s = (state_r == ST_IDLE) && clear_req;
  end

  // Clear engine: reset or clear_req restarts at entry 0; one entry per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear_req) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {AW{1'b0}};
          end
        end
        ST_CLEAR: begin
          // clear_req is deliberately not looked at here: no restart mid-clear.
          if (clr_idx_r == LAST_IDX) begin
            state_r   <= ST_IDLE;
            clr_idx_r <= {AW{1'b0}};
          end else begin
            clr_idx_r <= clr_idx_r + AW'(1);
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Storage has no reset; the clear engine zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_r[clr_idx_r] <= {XLEN{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[write_addr] <= write_value;
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_next_s;
  logic             issue_ok_s;

  // Next pending vector: a committed write retires, a later-applied issue wins.
  always_comb begin
    issue_ok_s     = issue_en && (state_r == ST_IDLE) &&
                     !(HAS_ZERO && (issue_addr == {AW{1'b0}}));
    pending_next_s = pending_r;
    if (wr_ok_s) begin
      pending_next_s[write_addr] = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
    if (issue_ok_s) begin
      pending_next_s[issue_addr] = 1'b1;
    end else begin
      pending_next_s[issue_addr] = pending_next_s[issue_addr];
    end
  end

  // Pending bits are wiped on entry to CLEAR and held at zero while clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= {DEPTH{1'b0}};
    end else if (busy || clear_start_s) begin
      pending_r <= {DEPTH{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end
`else
  logic unused_issue;
  assign unused_issue = &{1'b0, issue_en, issue_addr, clear_start_s};
`endif

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            pend_s;
    logic            entry_pend_s;

    assign addr_s = rd_addr[slice_lsb(g, AW) +: AW];

`ifdef REG_FILE_SCOREBOARD_EN
    assign entry_pend_s = pending_r[addr_s];
`else
    assign entry_pend_s = 1'b0;
`endif

    reg_file_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .busy          (busy),
      .addr          (addr_s),
      .wr_ok         (wr_ok_s),
      .write_addr    (write_addr),
      .write_value   (write_value),
      .entry         (mem_r[addr_s]),
      .entry_pending (entry_pend_s),
      .data          (data_s),
      .pending       (pend_s)
    );

    assign rd_data[slice_lsb(g, XLEN) +: XLEN] = data_s;
    assign rd_pending[g]                      = pend_s;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
//   Directed bench for reg_file_mp (XLEN=32, DEPTH=32, NUM_RD=2). A second
//   instance with ZERO_REG=0 shares the stimulus to cover the ordinary entry 0.
//   Define REG_FILE_SCOREBOARD_EN to also exercise the pending scoreboard.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req;
  logic            write_en;
  logic [AW-1:0]   write_addr;
  logic [XLEN-1:0] write_value;
  logic [AW-1:0]   ra0, ra1;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]     rd_data, rd_data_nz;
  logic            busy, busy_nz;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic [1:0]      rd_pending, rd_pending_nz;

  int total = 0;
  int bad   = 0;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .write_en(write_en),
    .write_addr(write_addr), .write_value(write_value), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .issue_en(issue_en),
    .issue_addr(issue_addr), .rd_pending(rd_pending)
  );

  reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .clear_req(clear_req), .write_en(write_en),
    .write_addr(write_addr), .write_value(write_value), .rd_addr(rd_addr),
    .rd_data(rd_data_nz), .busy(busy_nz), .issue_en(issue_en),
    .issue_addr(issue_addr), .rd_pending(rd_pending_nz)
  );

  typedef struct {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wval;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops; optional write / clear_req poke at given count.
  task automatic count_busy(output int cnt, input int poke_write_at, input int poke_clear_at);
    cnt = 0;
    while (busy && cnt < 100) begin
      write_en  = (cnt == poke_write_at);
      clear_req = (cnt == poke_clear_at);
      tick();
      cnt++;
    end
    write_en  = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    int cnt;
    logic all_zero;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd3,  32'h12345678, 32'h00000000};
    vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[5] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
    vecs[6] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h00000001, 32'h00000000};
    vecs[7] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd31, 32'h00000001, 32'h00000001};
    vecs[8] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd7,  32'hCAFEF00D, 32'h12345678};
    vecs[9] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd0,  32'hCAFEF00D, 32'h00000000};

    reset = 1'b1; clear_req = 1'b0; write_en = 1'b0; write_addr = '0;
    write_value = '0; ra0 = 5'd5; ra1 = 5'd9; issue_en = 1'b0; issue_addr = '0;

    // Reset state
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd1);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_pending", {62'd0, rd_pending}, 64'd0);
    tick(); tick();
    reset = 1'b0;

    // Busy for exactly DEPTH edges; a write on the last busy edge is dropped.
    write_addr = 5'd3; write_value = 32'hAAAA5555;
    count_busy(cnt, 31, -1);
    chk("post_reset_busy_edges", 64'(cnt), 64'd32);
    ra0 = 5'd3; ra1 = 5'd31;
    #1;
    chk("busy_write_dropped", rd_data, 64'd0);
    chk("busy_write_dropped_nz", rd_data_nz, 64'd0);

    // Table-driven write/read/bypass vectors.
    for (int i = 0; i < 10; i++) begin
      write_en = vecs[i].we; write_addr = vecs[i].waddr; write_value = vecs[i].wval;
      ra0 = vecs[i].a0; ra1 = vecs[i].a1;
      #1;
      chk($sformatf("vec%0d_port0", i), {32'd0, rd_data[31:0]}, {32'd0, vecs[i].exp0});
      chk($sformatf("vec%0d_port1", i), {32'd0, rd_data[63:32]}, {32'd0, vecs[i].exp1});
      chk($sformatf("vec%0d_pending", i), {62'd0, rd_pending}, 64'd0);
      tick();
    end
    write_en = 1'b0;

    // ZERO_REG=0 keeps the value written to entry 0 in vector 4.
    ra0 = 5'd0; ra1 = 5'd5;
    #1;
    chk("nz_entry0", {32'd0, rd_data_nz[31:0]}, 64'hFFFFFFFF);
    chk("nz_entry5", {32'd0, rd_data_nz[63:32]}, 64'hCAFEF00D);
    // Same-cycle bypass of address 0 on the ZERO_REG=0 instance only.
    write_en = 1'b1; write_addr = 5'd0; write_value = 32'h0BADF00D;
    #1;
    chk("zero_bypass_blocked", {32'd0, rd_data[31:0]}, 64'd0);
    chk("nz_bypass_entry0", {32'd0, rd_data_nz[31:0]}, 64'h0BADF00D);
    tick();
    write_en = 1'b0;

`ifdef REG_FILE_SCOREBOARD_EN
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    issue_en = 1'b0; ra0 = 5'd9; ra1 = 5'd3;
    #1;
    chk("sb_issue_pending", {62'd0, rd_pending}, 64'd1);
    // Write and reissue 9 together: bypass masks now, set wins after the edge.
    write_en = 1'b1; write_addr = 5'd9; write_value = 32'h00000099;
    issue_en = 1'b1; issue_addr = 5'd9;
    #1;
    chk("sb_bypass_masks", {62'd0, rd_pending}, 64'd0);
    tick();
    write_en = 1'b0; issue_en = 1'b0;
    #1;
    chk("sb_set_wins", {62'd0, rd_pending}, 64'd1);
    write_en = 1'b1; ra0 = 5'd3; ra1 = 5'd9;
    tick();
    write_en = 1'b0; ra0 = 5'd9;
    #1;
    chk("sb_write_clears", {62'd0, rd_pending}, 64'd0);
    issue_en = 1'b1; issue_addr = 5'd0;
    tick();
    issue_en = 1'b1; issue_addr = 5'd12; ra0 = 5'd0;
    tick();
    issue_en = 1'b0; ra1 = 5'd12;
    #1;
    chk("sb_zero_never_pending", {62'd0, rd_pending}, 64'd2);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    count_busy(cnt, -1, -1);
    #1;
    chk("sb_clear_wipes", {62'd0, rd_pending}, 64'd0);
`else
    issue_en = 1'b1; issue_addr = 5'd9; ra0 = 5'd9;
    tick();
    issue_en = 1'b0;
    #1;
    chk("no_sb_pending_tied", {62'd0, rd_pending}, 64'd0);
`endif

    // clear_req in IDLE; a second clear_req mid-clear must not restart it.
    write_en = 1'b1; write_addr = 5'd20; write_value = 32'h55AA55AA;
    tick();
    write_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clear_req_busy", {63'd0, busy}, 64'd1);
    count_busy(cnt, -1, 5);
    chk("clear_req_edges", 64'(cnt), 64'd32);
    ra0 = 5'd20; ra1 = 5'd5;
    #1;
    chk("clear_req_zeroed", rd_data, 64'd0);

    // Reset on the 10th clear cycle restarts a full DEPTH-edge clear.
    write_en = 1'b1; write_addr = 5'd17; write_value = 32'h77777777;
    tick();
    write_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    chk("mid_clear_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    count_busy(cnt, -1, -1);
    chk("mid_clear_reset_edges", 64'(cnt), 64'd32);
    all_zero = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = AW'(a); ra1 = AW'(DEPTH - 1 - a);
      #1;
      if (rd_data !== 64'd0 || rd_data_nz !== 64'd0) all_zero = 1'b0;
    end
    chk("all_entries_zero", {63'd0, all_zero}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
